// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch path.
// Entry layout pairs each fetched word with the byte address it came from.
package fetch_pkg;

  localparam int FETCH_FIFO_DEPTH = 2;
  localparam int FETCH_CNT_W      = 2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry queue of fetched words; slot 0 is always the head.
// Latency: push visible at head next cycle. No backpressure of its own; caller never overfills it.
module fetch_fifo
  import fetch_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  fetch_entry_t           push_dat,
  output logic [FETCH_CNT_W-1:0] count,
  output fetch_entry_t           head
);

  fetch_entry_t           slot_q [FETCH_FIFO_DEPTH];
  fetch_entry_t           slot_d [FETCH_FIFO_DEPTH];
  logic [FETCH_CNT_W-1:0] count_q, count_d;
  logic [FETCH_CNT_W-1:0] remain;
  logic                   pop_eff;

  always_comb begin
    slot_d  = slot_q;
    count_d = count_q;
    pop_eff = pop && (count_q != '0);
    remain  = count_q - {{(FETCH_CNT_W-1){1'b0}}, pop_eff};
    if (flush) begin
      // Slots keep their contents so the head outputs hold their last value.
      count_d = '0;
    end else begin
      if (pop_eff && (count_q == FETCH_CNT_W'(2))) begin
        slot_d[0] = slot_q[1];
      end
      if (push) begin
        slot_d[remain[0]] = push_dat;
      end
      count_d = remain + {{(FETCH_CNT_W-1){1'b0}}, push};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < FETCH_FIFO_DEPTH; i++) begin
        slot_q[i] <= '0;
      end
      count_q <= '0;
    end else begin
      slot_q  <= slot_d;
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign head  = slot_q[0];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: owns the PC, drives the memory address and queues returning words.
// Latency: first word valid two cycles after issue. Issue pauses when queue plus in-flight would exceed two.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] icache_addr,
  input  logic [31:0] icache_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc
);

  logic [31:0]            fetch_pc_q, fetch_pc_d;
  logic [31:0]            inflight_pc_q, inflight_pc_d;
  logic                   inflight_q, inflight_d;
  logic [FETCH_CNT_W-1:0] count;
  fetch_entry_t           head;
  fetch_entry_t           push_dat;
  logic                   push;
  logic                   pop;
  logic                   issue;
  logic [2:0]             occupancy;
  logic [31:0]            target;

  assign target    = align_pc(redirect_pc);
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;

  always_comb begin
    occupancy     = {1'b0, count} + {2'b00, inflight_q} - {2'b00, pop};
    issue         = (occupancy < 3'd2);
    fetch_pc_d    = fetch_pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    push          = 1'b0;
    push_dat      = '{pc: inflight_pc_q, instr: icache_instr};
    icache_addr   = fetch_pc_q;
    if (redirect_valid) begin
      // The response arriving now belongs to the old stream and is dropped.
      icache_addr   = target;
      inflight_d    = 1'b1;
      inflight_pc_d = target;
      fetch_pc_d    = target + 32'd4;
    end else begin
      push = inflight_q;
      if (issue) begin
        inflight_d    = 1'b1;
        inflight_pc_d = fetch_pc_q;
        fetch_pc_d    = fetch_pc_q + 32'd4;
      end
    end
    if (reset) begin
      icache_addr = RESET_PC;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q    <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

  fetch_fifo u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .pop      (pop),
    .flush    (redirect_valid),
    .push_dat (push_dat),
    .count    (count),
    .head     (head)
  );

  assign out_instr = head.instr;
  assign out_pc    = head.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios then random ready/redirect/reset traffic.
// Reference: delivered PCs form a +4 stream from the last restart; valid from two cycles after it.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk;
  logic        reset;
  logic [31:0] icache_addr;
  logic [31:0] icache_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;

  int total = 0;
  int bad   = 0;

  // Model state: cycles since last restart, restart cause, next PC decode should see.
  int          since      = 0;
  bit          by_reset   = 1'b1;
  logic [31:0] exp_pc     = RST_PC;

  fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk            (clk),
    .reset          (reset),
    .icache_addr    (icache_addr),
    .icache_instr   (icache_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h1000_0000 + (a >> 2);
  endfunction

  // Synchronous one-cycle instruction memory.
  always @(posedge clk) icache_instr <= mem_word(icache_addr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step(input logic rdy, input logic rv, input logic [31:0] rp, input logic rst);
    logic exp_valid;
    @(negedge clk);
    out_ready      = rdy;
    redirect_valid = rv;
    redirect_pc    = rp;
    reset          = rst;
    #1;
    exp_valid = (since >= 2);
    chk("out_valid", {31'd0, out_valid}, {31'd0, exp_valid});
    if (rst)
      chk("addr_reset", icache_addr, RST_PC);
    else if (rv)
      chk("addr_redirect", icache_addr, {rp[31:2], 2'b00});
    if (since < 2 && by_reset) begin
      chk("pc_after_reset", out_pc, 32'd0);
      chk("instr_after_reset", out_instr, 32'd0);
    end
    if (exp_valid && rdy) begin
      chk("out_pc", out_pc, exp_pc);
      chk("out_instr", out_instr, mem_word(exp_pc));
      exp_pc = exp_pc + 32'd4;
    end
    if (rst) begin
      since    = 0;
      by_reset = 1'b1;
      exp_pc   = RST_PC;
    end else if (rv) begin
      since    = 1;
      by_reset = 1'b0;
      exp_pc   = {rp[31:2], 2'b00};
    end else if (since < 2) begin
      since++;
    end
  endtask

  initial begin
    reset          = 1'b1;
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    repeat (2) @(posedge clk);

    // Reset held, a redirect during reset must be ignored.
    step(1'b1, 1'b0, 32'd0, 1'b1);
    step(1'b1, 1'b1, 32'h100, 1'b1);
    step(1'b1, 1'b0, 32'd0, 1'b1);

    // Streaming with decode always ready.
    repeat (8) step(1'b1, 1'b0, 32'd0, 1'b0);

    // Stall five cycles, then release.
    repeat (5) step(1'b0, 1'b0, 32'd0, 1'b0);
    repeat (6) step(1'b1, 1'b0, 32'd0, 1'b0);

    // Redirect while stalled with a full queue.
    repeat (3) step(1'b0, 1'b0, 32'd0, 1'b0);
    step(1'b0, 1'b1, 32'h40, 1'b0);
    repeat (6) step(1'b1, 1'b0, 32'd0, 1'b0);

    // Redirect with an unaligned target in the same cycle as a pop.
    step(1'b1, 1'b1, 32'h43, 1'b0);
    repeat (5) step(1'b1, 1'b0, 32'd0, 1'b0);

    // Redirect at the top of the address space: PC wraps to zero.
    step(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0);
    repeat (5) step(1'b1, 1'b0, 32'd0, 1'b0);

    // Back-to-back redirects: the later one wins.
    step(1'b1, 1'b1, 32'h200, 1'b0);
    step(1'b1, 1'b1, 32'h300, 1'b0);
    repeat (5) step(1'b1, 1'b0, 32'd0, 1'b0);

    // Reset mid-stream with the queue full.
    repeat (3) step(1'b0, 1'b0, 32'd0, 1'b0);
    step(1'b0, 1'b0, 32'd0, 1'b1);
    repeat (8) step(1'b1, 1'b0, 32'd0, 1'b0);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      logic        rdy, rv, rst;
      logic [31:0] rp;
      rdy = ($urandom_range(3) != 0);
      rv  = ($urandom_range(11) == 0);
      rst = ($urandom_range(79) == 0);
      rp  = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | ($urandom() & 32'hF)) : $urandom();
      step(rdy, rv, rp, rst);
    end
    repeat (4) step(1'b1, 1'b0, 32'd0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
